// File: rtl/shift_arbiter.sv
// Two-requester front end for a shared external 64-bit right shifter.
// Requester 0 is the integer ALU (SRL/SRA/SRLW/SRAW) and requester 1 is the
// FPU mantissa-alignment path. Arbitration is round-robin and uses a
// valid/ready handshake. Results go into one registered response slot, one
// cycle after the request is accepted.
module shift_arbiter #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned SHW  = 6
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [XLEN-1:0] i_req0_data,
  input  logic [SHW-1:0]  i_req0_shamt,
  input  logic            i_req0_sra,
  input  logic            i_req0_word,
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [XLEN-1:0] i_req1_data,
  input  logic [SHW-1:0]  i_req1_shamt,
  output logic [XLEN-1:0] o_sh_a,
  output logic [SHW-1:0]  o_sh_b,
  output logic            o_sh_sra,
  input  logic [XLEN-1:0] i_sh_result,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_rsp_id,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_sticky
);

  localparam int unsigned HalfW = XLEN / 2;

  logic            r_rsp_valid;
  logic            r_rsp_id;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_sticky;
  // Last winner. It resets to 1, so req0 wins the first contention.
  logic            r_rr_last;

  logic            w_slot_free;
  logic            w_win0;
  logic            w_win1;
  logic            w_xfer;
  logic            w_word_op;
  logic [XLEN-1:0] w_sh_a;
  logic [SHW-1:0]  w_sh_b;
  logic            w_sh_sra;
  logic [XLEN-1:0] w_lsb_mask;
  logic [XLEN-1:0] w_res;
  logic            w_sticky;

  // Grant logic: a lone requester wins, and on contention the requester
  // that did not win last time wins. No grant is given while in reset or
  // while the response slot is blocked.
  always_comb begin
    w_slot_free  = !r_rsp_valid || i_rsp_ready;
    w_win1       = i_req1_valid && (!i_req0_valid || !r_rr_last);
    w_win0       = i_req0_valid && !w_win1;
    o_req0_ready = i_reset_n && w_slot_free && w_win0;
    o_req1_ready = i_reset_n && w_slot_free && w_win1;
    w_xfer       = o_req0_ready || o_req1_ready;
  end

  // Operand steering to the shifter. The req0 fields are used whenever req1
  // is not winning, including cycles with no grant (the result is ignored).
  always_comb begin
    w_word_op = 1'b0;
    w_sh_a    = i_req0_data;
    w_sh_b    = i_req0_shamt;
    w_sh_sra  = i_req0_sra;
    if (w_win1) begin
      w_sh_a   = i_req1_data;
      w_sh_b   = i_req1_shamt;
      w_sh_sra = 1'b0;
    end else if (i_req0_word) begin
      // W-op: pre-extend the low word so SRAW shifts in bit 31. The amount
      // is limited to 5 bits.
      w_word_op = 1'b1;
      w_sh_a    = {{HalfW{i_req0_data[HalfW-1] & i_req0_sra}}, i_req0_data[HalfW-1:0]};
      w_sh_b    = {1'b0, i_req0_shamt[SHW-2:0]};
    end
    o_sh_a   = w_sh_a;
    o_sh_b   = w_sh_b;
    o_sh_sra = w_sh_sra;
  end

  // Result formatting and sticky bit. The sticky bit is the OR of the
  // operand bits that shift out, taken from the steered (already masked)
  // operand and amount.
  always_comb begin
    w_lsb_mask = (XLEN'(1) << w_sh_b) - XLEN'(1);
    w_sticky   = |(w_sh_a & w_lsb_mask);
    w_res      = i_sh_result;
    if (w_word_op) begin
      w_res = {{HalfW{i_sh_result[HalfW-1]}}, i_sh_result[HalfW-1:0]};
    end
  end

  // Response slot and round-robin pointer. Data fields hold their value
  // when the slot drains.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_sticky <= 1'b0;
      r_rr_last    <= 1'b1;
    end else if (w_xfer) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_win1;
      r_rsp_data   <= w_res;
      r_rsp_sticky <= w_sticky;
      r_rr_last    <= w_win1;
    end else if (i_rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_sticky = r_rsp_sticky;

endmodule
